// File: rtl/ram_wr_ctrl.sv
// Port-A write controller: writes one pass of (pass_cnt + addr) data, then raises rd_flag for the reader.
// Define RAM_WR_AUTO_RESTART_EN to loop passes forever after the first start.
module ram_wr_ctrl #(
  parameter int RW_CNT_MAX = 64,
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  output logic              ram_en_a,
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              rd_flag,
  output logic              busy,
  output logic              done,
  output logic [7:0]        pass_cnt
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t            state, state_nxt;
  logic [7:0]        rd_cnt, rd_cnt_nxt;
  logic              last_wr, last_rd;
  logic              en_nxt, rd_flag_nxt, busy_nxt, done_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [7:0]        pass_nxt;

  assign last_wr = (state == WRITE) && (ram_addr_a == ADDR_W'(RW_CNT_MAX - 1));
  assign last_rd = (state == READ)  && (rd_cnt == 8'(RW_CNT_MAX - 1));

  // State and every output are registered together so outputs track the state they describe.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      rd_cnt      <= '0;
      ram_en_a    <= 1'b0;
      ram_we_a    <= 1'b0;
      ram_addr_a  <= '0;
      ram_wr_data <= '0;
      rd_flag     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      rd_cnt      <= rd_cnt_nxt;
      ram_en_a    <= en_nxt;
      ram_we_a    <= en_nxt;
      ram_addr_a  <= addr_nxt;
      ram_wr_data <= data_nxt;
      rd_flag     <= rd_flag_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      pass_cnt    <= pass_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = WRITE;
      WRITE:   if (last_wr) state_nxt = READ;
      READ: begin
        if (last_rd) begin
`ifdef RAM_WR_AUTO_RESTART_EN
          state_nxt = WRITE;
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next-cycle output values; data uses the already-incremented pass count so an
  // auto-restarted pass starts from the new pass_cnt.
  always_comb begin
    pass_nxt    = pass_cnt + {7'd0, last_rd};
    done_nxt    = last_rd;
    en_nxt      = (state_nxt == WRITE);
    rd_flag_nxt = (state_nxt == READ);
    busy_nxt    = (state_nxt != IDLE);
    rd_cnt_nxt  = (state == READ && !last_rd) ? rd_cnt + 8'd1 : 8'd0;
    addr_nxt    = '0;
    data_nxt    = '0;
    if (state_nxt == WRITE) begin
      if (state == WRITE) addr_nxt = ram_addr_a + ADDR_W'(1);
      data_nxt = DATA_W'(pass_nxt) + DATA_W'(addr_nxt);
    end
  end

endmodule

// File: tb/tb_ram_wr_ctrl.sv
// Self-checking bench for ram_wr_ctrl: vector table plus hand-written pass sequences.
// Builds with or without RAM_WR_AUTO_RESTART_EN and checks the matching behaviour.
module tb_ram_wr_ctrl;

  localparam int RW_CNT_MAX = 64;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       start;
  logic       ram_en_a;
  logic       ram_we_a;
  logic [5:0] ram_addr_a;
  logic [7:0] ram_wr_data;
  logic       rd_flag;
  logic       busy;
  logic       done;
  logic [7:0] pass_cnt;

  int errors = 0;
  int checks = 0;

  ram_wr_ctrl #(.RW_CNT_MAX(RW_CNT_MAX), .ADDR_W(6), .DATA_W(8)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .start       (start),
    .ram_en_a    (ram_en_a),
    .ram_we_a    (ram_we_a),
    .ram_addr_a  (ram_addr_a),
    .ram_wr_data (ram_wr_data),
    .rd_flag     (rd_flag),
    .busy        (busy),
    .done        (done),
    .pass_cnt    (pass_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       rst_n;
    logic       start;
    logic       en;
    logic       we;
    logic [5:0] addr;
    logic [7:0] data;
    logic       rd;
    logic       busy;
    logic       done;
    logic [7:0] pass;
  } vec_t;

  vec_t vecs [6];

  // Inputs change 1ns after the rising edge, so outputs are sampled well away from it.
  task automatic applyStimulus(input logic rst_n, input logic st);
    sys_rst_n = rst_n;
    start     = st;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic e_en, input logic e_we,
                             input logic [5:0] e_addr, input logic [7:0] e_data,
                             input logic e_rd, input logic e_busy, input logic e_done,
                             input logic [7:0] e_pass);
    logic [26:0] act, exp;
    act = {ram_en_a, ram_we_a, ram_addr_a, ram_wr_data, rd_flag, busy, done, pass_cnt};
    exp = {e_en, e_we, e_addr, e_data, e_rd, e_busy, e_done, e_pass};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got en=%0b we=%0b addr=%0d data=%0d rd=%0b busy=%0b done=%0b pass=%0d, want en=%0b we=%0b addr=%0d data=%0d rd=%0b busy=%0b done=%0b pass=%0d",
               name, ram_en_a, ram_we_a, ram_addr_a, ram_wr_data, rd_flag, busy, done, pass_cnt,
               e_en, e_we, e_addr, e_data, e_rd, e_busy, e_done, e_pass);
    end
  endtask

  // Pass index i: 0..63 writes addr i with data p+i, 64..127 is the read window.
  task automatic checkPass(input int p, input bit kick, input bit doneFirst,
                           input bit pulses, input int lastIdx);
    logic st;
    for (int i = 0; i <= lastIdx; i++) begin
      st = (i == 0) ? kick : (pulses && (i == 10 || i == 90));
      applyStimulus(1'b1, st);
      if (i < RW_CNT_MAX)
        checkOutput($sformatf("pass%0d_wr%0d", p, i), 1'b1, 1'b1, 6'(i), 8'(p + i),
                    1'b0, 1'b1, (i == 0) && doneFirst, 8'(p));
      else
        checkOutput($sformatf("pass%0d_rd%0d", p, i), 1'b0, 1'b0, 6'd0, 8'd0,
                    1'b1, 1'b1, 1'b0, 8'(p));
    end
    start = 1'b0;
  endtask

  task automatic checkDone(input int expPass, input logic st);
    applyStimulus(1'b1, st);
    checkOutput($sformatf("done_pass%0d", expPass), 1'b0, 1'b0, 6'd0, 8'd0,
                1'b0, 1'b0, 1'b1, 8'(expPass));
  endtask

  task automatic checkIdle(input string name, input int expPass);
    applyStimulus(1'b1, 1'b0);
    checkOutput(name, 1'b0, 1'b0, 6'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'(expPass));
  endtask

  // Back-to-back passes with start held high; only the done cycles are compared.
  task automatic fastForward(input int fromP, input int n);
    for (int k = 0; k < n; k++) begin
      repeat (2 * RW_CNT_MAX) applyStimulus(1'b1, 1'b1);
      checkDone(8'(fromP + k + 1), (k != n - 1));
    end
    start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 6'd1, 8'd1, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'd2, 8'd2, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0};

    sys_rst_n = 1'b0;
    start     = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("in_reset", 1'b0, 1'b0, 6'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);

    for (int i = 0; i < 20; i++) checkIdle($sformatf("idle%0d", i), 0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].start);
      checkOutput($sformatf("vec%0d", i), vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].data,
                  vecs[i].rd, vecs[i].busy, vecs[i].done, vecs[i].pass);
    end

`ifdef RAM_WR_AUTO_RESTART_EN
    $display("[TB] auto-restart: one start, three passes");
    checkPass(0, 1'b1, 1'b0, 1'b0, 127);
    checkPass(1, 1'b0, 1'b1, 1'b0, 127);
    checkPass(2, 1'b0, 1'b1, 1'b0, 127);
    applyStimulus(1'b1, 1'b0);
    checkOutput("auto_pass3_start", 1'b1, 1'b1, 6'd0, 8'd3, 1'b0, 1'b1, 1'b1, 8'd3);
`else
    $display("[TB] single pass");
    checkPass(0, 1'b1, 1'b0, 1'b0, 127);
    checkDone(1, 1'b0);
    checkIdle("after_pass0", 1);

    $display("[TB] second pass and pattern wrap");
    checkPass(1, 1'b1, 1'b0, 1'b0, 127);
    checkDone(2, 1'b0);
    fastForward(2, 248);
    checkPass(250, 1'b1, 1'b0, 1'b0, 127);
    checkDone(251, 1'b0);

    $display("[TB] start ignored while busy");
    checkPass(251, 1'b1, 1'b0, 1'b1, 127);
    checkDone(252, 1'b0);
    for (int i = 0; i < 3; i++) checkIdle($sformatf("no_extra_done%0d", i), 252);

    $display("[TB] pass_cnt wrap");
    fastForward(252, 5);
    checkIdle("after_wrap", 1);

    $display("[TB] reset mid-write");
    checkPass(1, 1'b1, 1'b0, 1'b0, 30);
    sys_rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0, 1'b0, 6'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("reset_held", 1'b0, 1'b0, 6'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    checkPass(0, 1'b1, 1'b0, 1'b0, 127);
    checkDone(1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
